// File: rtl/pe_mac_seq_pkg.sv
// Shared constants and FSM state type for the pe_mac_seq job sequencer.
// Widths match pe_core so operands and results pass through unchanged.
package pe_mac_seq_pkg;

  localparam int PE_W_IN    = 8;
  localparam int PE_W_ACC   = 24;
  localparam int PE_LEN_W   = 10;
  localparam int PE_LAT_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    OUT
  } pe_seq_state_t;

endpackage

// File: rtl/pe_mac_seq_if.sv
// Job-side handshakes of pe_mac_seq: cfg (job request), op (operand
// pairs) and res (result), each valid/ready. slave = sequencer view.
interface pe_mac_seq_if
  import pe_mac_seq_pkg::*;
#(
  parameter int W_IN  = PE_W_IN,
  parameter int W_ACC = PE_W_ACC,
  parameter int LEN_W = PE_LEN_W
);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_relu;

  logic             op_valid;
  logic             op_ready;
  logic [W_IN-1:0]  op_a;
  logic [W_IN-1:0]  op_b;

  logic             res_valid;
  logic             res_ready;
  logic [W_ACC-1:0] res_data;

  modport slave (
    input  cfg_valid, cfg_len, cfg_relu,
    output cfg_ready,
    input  op_valid, op_a, op_b,
    output op_ready,
    output res_valid, res_data,
    input  res_ready
  );

  modport master (
    output cfg_valid, cfg_len, cfg_relu,
    input  cfg_ready,
    output op_valid, op_a, op_b,
    input  op_ready,
    input  res_valid, res_data,
    output res_ready
  );

endinterface

// File: rtl/pe_mac_seq.sv
// Job sequencer in front of pe_core: clear, stream pairs, drain, return.
// Ports: clk, reset, io (cfg/op/res), pe_* to pe_core, pe_results, busy.
module pe_mac_seq
  import pe_mac_seq_pkg::*;
#(
  parameter int W_IN   = PE_W_IN,
  parameter int W_ACC  = PE_W_ACC,
  parameter int LEN_W  = PE_LEN_W,
  parameter int PE_LAT = PE_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  pe_mac_seq_if.slave      io,
  output logic             pe_en,
  output logic             mode_sel,
  output logic             reg_reset,
  output logic [W_IN-1:0]  a_mul,
  output logic [W_IN-1:0]  b_mul,
  input  logic [W_ACC-1:0] pe_results,
  output logic             busy
);

  localparam int DRN_W =
    (PE_LAT > 2) ? $clog2(PE_LAT) : 1;

  pe_seq_state_t    state_q;
  pe_seq_state_t    state_d;
  logic [LEN_W-1:0] cnt_q;
  logic [DRN_W-1:0] drn_q;
  logic             relu_q;
  logic             rv_q;
  logic [W_ACC-1:0] rd_q;

  logic cfg_hs;
  logic op_hs;
  logic last_op;
  logic drn_done;
  logic res_hs;

  assign cfg_hs   = (state_q == IDLE) && io.cfg_valid;
  assign op_hs    = (state_q == STREAM) && io.op_valid;
  assign last_op  = op_hs && (cnt_q == LEN_W'(1));
  assign drn_done = (state_q == DRAIN) && (drn_q == '0);
  assign res_hs   = (state_q == OUT) && io.res_ready;

  assign busy         = (state_q != IDLE);
  // relu_q is frozen for the whole job; pe_core pipelines mode_sel
  assign mode_sel     = busy & relu_q;
  assign io.res_valid = rv_q;
  assign io.res_data  = rd_q;

  always_comb begin
    state_d      = state_q;
    io.cfg_ready = 1'b0;
    io.op_ready  = 1'b0;
    pe_en        = 1'b0;
    reg_reset    = 1'b0;
    a_mul        = '0;
    b_mul        = '0;
    unique case (state_q)
      IDLE: begin
        io.cfg_ready = 1'b1;
        if (io.cfg_valid) begin
          state_d = (io.cfg_len == '0) ? OUT : CLEAR;
        end
      end
      CLEAR: begin
        reg_reset = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        io.op_ready = 1'b1;
        pe_en       = io.op_valid;
        a_mul       = io.op_a;
        b_mul       = io.op_b;
        if (last_op) state_d = DRAIN;
      end
      DRAIN: begin
        if (drn_done) state_d = OUT;
      end
      OUT: begin
        if (io.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drn_q   <= '0;
      relu_q  <= 1'b0;
      rv_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (cfg_hs) begin
        cnt_q  <= io.cfg_len;
        relu_q <= io.cfg_relu;
        // empty job skips pe_core entirely
        if (io.cfg_len == '0) begin
          rd_q <= '0;
          rv_q <= 1'b1;
        end
      end
      if (op_hs) begin
        cnt_q <= cnt_q - LEN_W'(1);
        if (last_op) drn_q <= DRN_W'(PE_LAT - 1);
      end
      if (state_q == DRAIN) begin
        if (drn_done) begin
          rd_q <= pe_results;
          rv_q <= 1'b1;
        end else begin
          drn_q <= drn_q - DRN_W'(1);
        end
      end
      if (res_hs) rv_q <= 1'b0;
    end
  end

endmodule
